// File: rtl/bus_transaction_unit_if.sv
// Memory-side request/ready bus between the transaction unit and the memory/peripheral.
//   master : mem_req, mem_we, mem_addr, mem_wdata out; mem_rdata, mem_ready in
//   slave  : mirror of master
interface bus_transaction_unit_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/bus_transaction_unit.sv
// Single-word bus master behind the CPU control unit: accepts one read/write
// request at a time, runs a request/ready handshake on the memory side and
// returns one-cycle completion pulses (rdata_valid, write_done, bus_error).
// Misaligned addresses are rejected without touching the bus.
// Optional feature: define BUS_TIMEOUT_EN to abort an access that waits
// TIMEOUT_CYCLES cycles without mem_ready.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start_transaction  request strobe (sampled only when idle)
//   mode, addr, wdata  request: 0 = read / 1 = write, byte address, write data
//   rdata              last successfully read word
//   rdata_valid, write_done, bus_error  one-cycle completion pulses
//   busy               combinational, high while a transaction is in flight
//   mem                memory-side handshake (master modport)
module bus_transaction_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_transaction,
    input  logic                          mode,
    input  logic [31:0]                   addr,
    input  logic [31:0]                   wdata,
    output logic [31:0]                   rdata,
    output logic                          rdata_valid,
    output logic                          write_done,
    output logic                          bus_error,
    output logic                          busy,
    bus_transaction_unit_if.master        mem
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned WORD_W = 30;
    localparam int unsigned CNT_W  = 8;

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                mode_q, mode_d;
    logic [WORD_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rdata_valid_q, rdata_valid_d;
    logic                write_done_q, write_done_d;
    logic                bus_error_q, bus_error_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic                timeout_hit_c;

`ifdef BUS_TIMEOUT_EN
    logic [CNT_W-1:0]    wait_cnt_q;

    // Wait counter: zero outside ACCESS, counts ACCESS cycles without mem_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else if (state_q != ACCESS) begin
            wait_cnt_q <= '0;
        end else if (!mem.mem_ready) begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end
    end

    assign timeout_hit_c = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES));
`else
    assign timeout_hit_c = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus next values of every registered output and latch.
    // Completion pulses are computed on the transition into DONE so that they
    // are registered and visible exactly for the DONE cycle.
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        write_done_d  = 1'b0;
        bus_error_d   = 1'b0;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;

        unique case (state_q)
            IDLE: begin
                if (start_transaction) begin
                    mode_d  = mode;
                    addr_d  = addr[31:2];
                    wdata_d = wdata;
                    if (addr[1:0] == 2'b00) begin
                        state_d   = ACCESS;
                        mem_req_d = 1'b1;
                        mem_we_d  = mode;
                    end else begin
                        state_d     = DONE;
                        bus_error_d = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // mem_ready wins over a timeout in the same cycle.
                if (mem.mem_ready) begin
                    state_d       = DONE;
                    mem_req_d     = 1'b0;
                    mem_we_d      = 1'b0;
                    rdata_valid_d = !mode_q;
                    write_done_d  = mode_q;
                    if (!mode_q) begin
                        rdata_d = mem.mem_rdata;
                    end
                end else if (timeout_hit_c) begin
                    state_d     = DONE;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    bus_error_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q        <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            write_done_q  <= 1'b0;
            bus_error_q   <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            write_done_q  <= write_done_d;
            bus_error_q   <= bus_error_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
        end
    end

    assign rdata         = rdata_q;
    assign rdata_valid   = rdata_valid_q;
    assign write_done    = write_done_q;
    assign bus_error     = bus_error_q;
    assign busy          = (state_q != IDLE);
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = {addr_q, 2'b00};
    assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_bus_transaction_unit.sv
// Self-checking bench for bus_transaction_unit: directed cases followed by
// randomized transactions, checked against a transaction-level model.
module tb_bus_transaction_unit;

    localparam int unsigned TO = 4;
`ifdef BUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start_transaction;
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        write_done;
    logic        bus_error;
    logic        busy;

    bus_transaction_unit_if mem_if ();

    bus_transaction_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk               (clk),
        .rst               (rst),
        .start_transaction (start_transaction),
        .mode              (mode),
        .addr              (addr),
        .wdata             (wdata),
        .rdata             (rdata),
        .rdata_valid       (rdata_valid),
        .write_done        (write_done),
        .bus_error         (bus_error),
        .busy              (busy),
        .mem               (mem_if.master)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_rdata = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pulses();
        return {29'b0, rdata_valid, write_done, bus_error};
    endfunction

    task automatic check_idle(input string tag);
        check({tag, ".busy"},    32'(busy),           32'h0);
        check({tag, ".mem_req"}, 32'(mem_if.mem_req), 32'h0);
        check({tag, ".pulses"},  pulses(),            32'h0);
        check({tag, ".rdata"},   rdata,               exp_rdata);
    endtask

    // One transaction. waits = number of ACCESS cycles before mem_ready
    // (negative: never ready). noise adds ignored starts and stray mem_ready.
    task automatic run_txn(input bit m, input logic [31:0] a, input logic [31:0] wd,
                           input int waits, input logic [31:0] rd, input bit noise);
        bit          aligned;
        bit          timed_out;
        int          n_acc;
        logic [31:0] exp_p;

        aligned   = (a[1:0] == 2'b00);
        timed_out = 1'b0;
        start_transaction = 1'b1;
        mode  = m;
        addr  = a;
        wdata = wd;
        step();
        start_transaction = 1'b0;
        mode  = 1'($urandom);
        addr  = $urandom;
        wdata = $urandom;

        if (aligned) begin
            timed_out = TO_EN && (waits < 0 || waits > int'(TO));
            n_acc     = timed_out ? int'(TO) + 1 : waits + 1;
            for (int k = 0; k < n_acc; k++) begin
                check("acc.busy",      32'(busy),           32'h1);
                check("acc.mem_req",   32'(mem_if.mem_req), 32'h1);
                check("acc.mem_we",    32'(mem_if.mem_we),  32'(m));
                check("acc.mem_addr",  mem_if.mem_addr,     {a[31:2], 2'b00});
                check("acc.mem_wdata", mem_if.mem_wdata,    wd);
                check("acc.pulses",    pulses(),            32'h0);
                check("acc.rdata",     rdata,               exp_rdata);
                mem_if.mem_ready = (k == waits);
                mem_if.mem_rdata = (k == waits) ? rd : $urandom;
                if (noise) begin
                    start_transaction = (k == 0) ? 1'b1 : 1'($urandom);
                    addr = 32'h300;
                    mode = 1'($urandom);
                end
                step();
                mem_if.mem_ready  = 1'b0;
                start_transaction = 1'b0;
            end
            if (timed_out) begin
                exp_p = 32'h1;
            end else begin
                exp_p = m ? 32'h2 : 32'h4;
                if (!m) exp_rdata = rd;
            end
        end else begin
            exp_p = 32'h1;
        end

        check("done.busy",    32'(busy),           32'h1);
        check("done.mem_req", 32'(mem_if.mem_req), 32'h0);
        check("done.mem_we",  32'(mem_if.mem_we),  32'h0);
        check("done.pulses",  pulses(),            exp_p);
        check("done.rdata",   rdata,               exp_rdata);
        if (noise) begin
            start_transaction = 1'b1;
            addr = 32'h300;
            mem_if.mem_ready = 1'($urandom);
            mem_if.mem_rdata = $urandom;
        end
        step();
        start_transaction = 1'b0;
        check_idle("post");
        if (noise) begin
            // stray mem_ready while idle must be ignored
            mem_if.mem_ready = 1'b1;
            mem_if.mem_rdata = $urandom;
            step();
            mem_if.mem_ready = 1'b0;
            check_idle("idle_ready");
        end
    endtask

    initial begin
        logic [31:0] a;
        rst               = 1'b1;
        start_transaction = 1'b0;
        mode              = 1'b0;
        addr              = 32'h0;
        wdata             = 32'h0;
        mem_if.mem_ready  = 1'b0;
        mem_if.mem_rdata  = 32'h0;
        step();
        step();
        rst = 1'b0;
        step();

        check("rst.rdata",     rdata,               32'h0);
        check("rst.pulses",    pulses(),            32'h0);
        check("rst.busy",      32'(busy),           32'h0);
        check("rst.mem_req",   32'(mem_if.mem_req), 32'h0);
        check("rst.mem_we",    32'(mem_if.mem_we),  32'h0);
        check("rst.mem_addr",  mem_if.mem_addr,     32'h0);
        check("rst.mem_wdata", mem_if.mem_wdata,    32'h0);

        run_txn(1'b0, 32'h100, $urandom, 0, 32'hDEADBEEF, 1'b0);
        run_txn(1'b1, 32'h204, 32'h12345678, 3, $urandom, 1'b0);
        run_txn(1'b0, 32'h103, $urandom, 0, $urandom, 1'b0);
        run_txn(1'b0, 32'h100, $urandom, 2, 32'hCAFEF00D, 1'b1);

        // Asynchronous reset in the second wait cycle of a read.
        start_transaction = 1'b1;
        mode  = 1'b0;
        addr  = 32'h40;
        wdata = 32'hA5A5A5A5;
        step();
        start_transaction = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        exp_rdata = 32'h0;
        check("arst.mem_req",   32'(mem_if.mem_req), 32'h0);
        check("arst.busy",      32'(busy),           32'h0);
        check("arst.rdata",     rdata,               32'h0);
        check("arst.mem_addr",  mem_if.mem_addr,     32'h0);
        check("arst.mem_wdata", mem_if.mem_wdata,    32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_if.mem_ready = 1'b1;
        step();
        mem_if.mem_ready = 1'b0;
        check_idle("arst.after");
        step();
        check_idle("arst.after2");
        run_txn(1'b0, 32'h44, $urandom, 1, 32'h0BADC0DE, 1'b0);

        if (TO_EN) begin
            run_txn(1'b0, 32'h80, $urandom, -1, $urandom, 1'b0);
            run_txn(1'b0, 32'h84, $urandom, int'(TO), 32'h13579BDF, 1'b0);
            run_txn(1'b1, 32'h88, $urandom, int'(TO) + 1, $urandom, 1'b0);
        end

        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
            run_txn(1'($urandom), a, $urandom, int'($urandom_range(0, 6)),
                    $urandom, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
